// File: rtl/window_sad_tracker.sv
`default_nettype none
// ============================================================================
// Module      : window_sad_tracker
// Description : Accumulates the sum of absolute differences over fixed-size
//               windows and tracks the smallest window SAD and its position.
// Revision    : 1.0 - initial release
// ============================================================================
module window_sad_tracker #(
  parameter int DATA_W = 8,
  parameter int SAMP_N = 16,
  parameter int POS_W  = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              DataValid,
  input  logic [DATA_W-1:0] FrameData,
  input  logic [DATA_W-1:0] TmplData,
  input  logic              LastWindow,
  output logic              Busy,
  output logic              WinValid,
  output logic [15:0]       WinSAD,
  output logic [15:0]       MinSAD,
  output logic [POS_W-1:0]  MinPos,
  output logic              Done
);

  localparam int c_cnt_w = (SAMP_N > 1) ? $clog2(SAMP_N) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(SAMP_N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [15:0]         r_acc;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [POS_W-1:0]    r_pos;
  logic [DATA_W-1:0]   w_diff;
  logic [15:0]         w_total;
  logic                w_start;
  logic                w_accept;
  logic                w_final;

  always_comb begin
    w_diff   = (FrameData >= TmplData) ? (FrameData - TmplData) : (TmplData - FrameData);
    w_total  = r_acc + 16'(w_diff);
    w_start  = (r_state == S_IDLE) && Start;
    w_accept = (r_state == S_RUN) && DataValid;
    w_final  = w_accept && (r_cnt == c_last_cnt);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (Start) w_next_state = S_RUN;
      S_RUN:    if (w_final && LastWindow) w_next_state = S_FINISH;
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_pos    <= '0;
      Busy     <= 1'b0;
      WinValid <= 1'b0;
      Done     <= 1'b0;
      WinSAD   <= '0;
      MinSAD   <= 16'hFFFF;
      MinPos   <= '0;
    end else begin
      WinValid <= 1'b0;
      Done     <= (w_next_state == S_FINISH);
      Busy     <= (w_next_state != S_IDLE);
      if (w_start) begin
        r_acc  <= '0;
        r_cnt  <= '0;
        r_pos  <= '0;
        MinSAD <= 16'hFFFF;
        MinPos <= '0;
      end else if (w_accept) begin
        if (w_final) begin
          WinSAD   <= w_total;
          WinValid <= 1'b1;
          // Strict compare so ties keep the earliest window.
          if (w_total < MinSAD) begin
            MinSAD <= w_total;
            MinPos <= r_pos;
          end
          r_acc <= '0;
          r_cnt <= '0;
          r_pos <= r_pos + POS_W'(1);
        end else begin
          r_acc <= w_total;
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire
